// File: rtl/axi4lite_io_arbiter.sv
// Two-requester round-robin arbiter that shares one AXI4-Lite master port.
// Each accepted command runs exactly one AXI transaction and ends with a one-cycle done pulse.
module axi4lite_io_arbiter #(
   parameter int C_M_AXI_ADDR_WIDTH = 4,
   parameter int C_M_AXI_DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,

   input  logic                            req0_valid,
   output logic                            req0_ready,
   input  logic                            req0_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req0_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   req0_wdata,
   output logic                            req0_done,
   output logic [1:0]                      req0_resp,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   req0_rdata,

   input  logic                            req1_valid,
   output logic                            req1_ready,
   input  logic                            req1_we,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req1_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   req1_wdata,
   output logic                            req1_done,
   output logic [1:0]                      req1_resp,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   req1_rdata,

   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY,

   output logic                            busy
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

   typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, DONE} state_t;

   state_t          r_state;
   logic            r_lastGrant;
   logic            r_id;
   logic            r_live;
   logic            r_awvalid;
   logic            r_wvalid;
   logic            r_bready;
   logic            r_arvalid;
   logic            r_rready;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic            r_done0;
   logic            r_done1;
   logic [1:0]      r_resp0;
   logic [1:0]      r_resp1;
   logic [DW-1:0]   r_rdata0;
   logic [DW-1:0]   r_rdata1;

   logic            w_grant;
   logic            w_idle;
   logic            w_accept;
   logic            w_selWe;
   logic [AW-1:0]   w_selAddr;
   logic [DW-1:0]   w_selWdata;
   logic            w_awDone;
   logic            w_wDone;
   logic            w_finish;
   logic [1:0]      w_finResp;
   logic [DW-1:0]   w_finData;

   // r_live keeps both readies low until the first clock after reset release,
   // so a requester holding valid through reset cannot see ready during reset.
   always_comb begin
      w_grant    = (req0_valid && req1_valid) ? ~r_lastGrant : req1_valid;
      w_idle     = r_live && (r_state == IDLE);
      w_accept   = w_idle && (req0_valid || req1_valid);
      w_selWe    = w_grant ? req1_we    : req0_we;
      w_selAddr  = w_grant ? req1_addr  : req0_addr;
      w_selWdata = w_grant ? req1_wdata : req0_wdata;
      w_awDone   = !r_awvalid || M_AXI_AWREADY;
      w_wDone    = !r_wvalid  || M_AXI_WREADY;
      w_finish   = ((r_state == WB) && M_AXI_BVALID) || ((r_state == RD) && M_AXI_RVALID);
      w_finResp  = (r_state == RD) ? M_AXI_RRESP : M_AXI_BRESP;
      w_finData  = (r_state == RD) ? M_AXI_RDATA : '0;
   end

   assign req0_ready    = w_idle && req0_valid && !w_grant;
   assign req1_ready    = w_idle && req1_valid && w_grant;
   assign req0_done     = r_done0;
   assign req1_done     = r_done1;
   assign req0_resp     = r_resp0;
   assign req1_resp     = r_resp1;
   assign req0_rdata    = r_rdata0;
   assign req1_rdata    = r_rdata1;
   assign M_AXI_AWADDR  = r_addr;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;
   assign busy          = (r_state != IDLE);

   // Sequencer: one command at a time, AW and W retire independently,
   // and the completion is routed to whichever requester owns the command.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state     <= IDLE;
         r_lastGrant <= 1'b1;
         r_id        <= 1'b0;
         r_live      <= 1'b0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_resp0     <= 2'b00;
         r_resp1     <= 2'b00;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         r_live  <= 1'b1;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_id        <= w_grant;
                  r_lastGrant <= w_grant;
                  r_addr      <= w_selAddr & ALIGN_MASK;
                  r_wdata     <= w_selWdata;
                  if (w_selWe) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= WR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= RA;
                  end
               end
            end
            WR: begin
               if (M_AXI_AWREADY) r_awvalid <= 1'b0;
               if (M_AXI_WREADY)  r_wvalid  <= 1'b0;
               if (w_awDone && w_wDone) begin
                  r_bready <= 1'b1;
                  r_state  <= WB;
               end
            end
            WB: begin
               if (M_AXI_BVALID) begin
                  r_bready <= 1'b0;
                  r_state  <= DONE;
               end
            end
            RA: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= RD;
               end
            end
            RD: begin
               if (M_AXI_RVALID) begin
                  r_rready <= 1'b0;
                  r_state  <= DONE;
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
         if (w_finish) begin
            if (r_id) begin
               r_done1  <= 1'b1;
               r_resp1  <= w_finResp;
               r_rdata1 <= w_finData;
            end else begin
               r_done0  <= 1'b1;
               r_resp0  <= w_finResp;
               r_rdata0 <= w_finData;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi4lite_io_arbiter.sv
// Self-checking bench for axi4lite_io_arbiter: a small AXI4-Lite slave model with
// programmable delays, a vector table of single commands, and multi-cycle sequences.
module tb_axi4lite_io_arbiter;

   localparam int AW = 4;
   localparam int DW = 32;

   logic            ACLK = 1'b0;
   logic            ARESETN;
   logic            req0_valid, req0_ready, req0_we, req0_done;
   logic [AW-1:0]   req0_addr;
   logic [DW-1:0]   req0_wdata, req0_rdata;
   logic [1:0]      req0_resp;
   logic            req1_valid, req1_ready, req1_we, req1_done;
   logic [AW-1:0]   req1_addr;
   logic [DW-1:0]   req1_wdata, req1_rdata;
   logic [1:0]      req1_resp;
   logic [AW-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
   logic [2:0]      M_AXI_AWPROT, M_AXI_ARPROT;
   logic            M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [DW-1:0]   M_AXI_WDATA, M_AXI_RDATA;
   logic [3:0]      M_AXI_WSTRB;
   logic [1:0]      M_AXI_BRESP, M_AXI_RRESP;
   logic            M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic            M_AXI_RVALID, M_AXI_RREADY;
   logic            busy;

   always #5 ACLK = ~ACLK;

   axi4lite_io_arbiter #(.C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_done(req0_done),
      .req0_resp(req0_resp), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_done(req1_done),
      .req1_resp(req1_resp), .req1_rdata(req1_rdata),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .busy(busy)
   );

   // Slave model: each ready/valid comes up after a programmable number of waiting cycles.
   int           awDelay = 0, wDelay = 0, bDelay = 0, rDelay = 0;
   logic [1:0]   slvBresp = 2'b00, slvRresp = 2'b00;
   logic [DW-1:0] mem [4];
   int           awCnt, wCnt, bCnt, rCnt;
   logic         gotAw, gotW, bPend, rPend;
   logic [AW-1:0] wAddr, rAddr;
   logic [DW-1:0] wData;

   assign M_AXI_AWREADY = M_AXI_AWVALID && !gotAw && (awCnt >= awDelay);
   assign M_AXI_WREADY  = M_AXI_WVALID && !gotW && (wCnt >= wDelay);
   assign M_AXI_BVALID  = bPend && (bCnt >= bDelay);
   assign M_AXI_BRESP   = slvBresp;
   assign M_AXI_ARREADY = M_AXI_ARVALID && !rPend;
   assign M_AXI_RVALID  = rPend && (rCnt >= rDelay);
   assign M_AXI_RDATA   = M_AXI_RVALID ? mem[rAddr[3:2]] : '0;
   assign M_AXI_RRESP   = slvRresp;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         awCnt <= 0; wCnt <= 0; bCnt <= 0; rCnt <= 0;
         gotAw <= 1'b0; gotW <= 1'b0; bPend <= 1'b0; rPend <= 1'b0;
         wAddr <= '0; rAddr <= '0; wData <= '0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         if (M_AXI_AWVALID && !M_AXI_AWREADY && !gotAw) awCnt <= awCnt + 1;
         if (M_AXI_WVALID && !M_AXI_WREADY && !gotW) wCnt <= wCnt + 1;
         if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            gotAw <= 1'b1; wAddr <= M_AXI_AWADDR; awCnt <= 0;
         end
         if (M_AXI_WVALID && M_AXI_WREADY) begin
            gotW <= 1'b1; wData <= M_AXI_WDATA; wCnt <= 0;
         end
         if ((gotAw || M_AXI_AWREADY) && (gotW || M_AXI_WREADY) && !bPend) begin
            bPend <= 1'b1; gotAw <= 1'b0; gotW <= 1'b0;
         end
         if (bPend && !M_AXI_BVALID) bCnt <= bCnt + 1;
         if (M_AXI_BVALID && M_AXI_BREADY) begin
            bPend <= 1'b0; bCnt <= 0; mem[wAddr[3:2]] <= wData;
         end
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            rPend <= 1'b1; rAddr <= M_AXI_ARADDR;
         end
         if (rPend && !M_AXI_RVALID) rCnt <= rCnt + 1;
         if (M_AXI_RVALID && M_AXI_RREADY) begin
            rPend <= 1'b0; rCnt <= 0;
         end
      end
   end

   // Monitors: these counters never reset, so sequences compare before/after snapshots.
   int            acc0 = 0, acc1 = 0, done0Cnt = 0, done1Cnt = 0;
   int            awHigh = 0, wHigh = 0, bReadyHigh = 0, bWait = 0;
   logic          grantQ [$];
   logic [AW-1:0] lastAwaddr = '0, lastAraddr = '0;
   logic [DW-1:0] lastWdata = '0;
   logic [3:0]    lastWstrb = '0;

   always @(posedge ACLK) begin
      if (req0_valid && req0_ready) begin acc0 <= acc0 + 1; grantQ.push_back(1'b0); end
      if (req1_valid && req1_ready) begin acc1 <= acc1 + 1; grantQ.push_back(1'b1); end
      if (req0_done) done0Cnt <= done0Cnt + 1;
      if (req1_done) done1Cnt <= done1Cnt + 1;
      if (M_AXI_AWVALID && M_AXI_AWREADY) lastAwaddr <= M_AXI_AWADDR;
      if (M_AXI_WVALID && M_AXI_WREADY) begin lastWdata <= M_AXI_WDATA; lastWstrb <= M_AXI_WSTRB; end
      if (M_AXI_ARVALID && M_AXI_ARREADY) lastAraddr <= M_AXI_ARADDR;
      if (M_AXI_AWVALID) awHigh <= awHigh + 1;
      if (M_AXI_WVALID) wHigh <= wHigh + 1;
      if (M_AXI_BREADY) bReadyHigh <= bReadyHigh + 1;
      if (M_AXI_BREADY && !M_AXI_BVALID) bWait <= bWait + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Issues one command and waits for its done pulse; lat counts falling edges after the accept edge.
   task automatic applyStimulus(input logic id, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, output bit ok, output int lat,
                                output logic [1:0] resp, output logic [DW-1:0] rdata);
      int n = 0;
      lat = 0; resp = 2'b00; rdata = '0; ok = 1'b0;
      @(negedge ACLK);
      if (id) begin req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata; end
      else    begin req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata; end
      #1;
      while (!(id ? req1_ready : req0_ready) && n < 50) begin
         @(negedge ACLK); #1; n++;
      end
      if (n < 50) begin
         @(posedge ACLK); #1;
         req0_valid = 1'b0; req1_valid = 1'b0;
         while (lat < 60) begin
            @(negedge ACLK); lat++;
            if (id ? req1_done : req0_done) begin
               ok = 1'b1;
               resp = id ? req1_resp : req0_resp;
               rdata = id ? req1_rdata : req0_rdata;
               break;
            end
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   typedef struct {
      logic          id;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [1:0]    slvResp;
      logic [AW-1:0] expAddr;
      logic [1:0]    expResp;
      logic [DW-1:0] expRdata;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit            ok;
      int            lat, n, b0, b1, a0, a1, s0, s1, s2, s3;
      logic [1:0]    resp;
      logic [DW-1:0] rdata;
      logic [7:0]    ord;

      vecs[0]  = '{1'b0, 1'b1, 4'h0, 32'h0000_0001, 2'b00, 4'h0, 2'b00, 32'h0};
      vecs[1]  = '{1'b0, 1'b1, 4'h4, 32'h0000_0002, 2'b00, 4'h4, 2'b00, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, 4'h8, 32'h0000_0003, 2'b00, 4'h8, 2'b00, 32'h0};
      vecs[3]  = '{1'b0, 1'b1, 4'hC, 32'h0000_0004, 2'b00, 4'hC, 2'b00, 32'h0};
      vecs[4]  = '{1'b1, 1'b0, 4'h0, 32'h0,         2'b00, 4'h0, 2'b00, 32'h1};
      vecs[5]  = '{1'b1, 1'b0, 4'h4, 32'h0,         2'b00, 4'h4, 2'b00, 32'h2};
      vecs[6]  = '{1'b1, 1'b0, 4'h8, 32'h0,         2'b00, 4'h8, 2'b00, 32'h3};
      vecs[7]  = '{1'b1, 1'b0, 4'hC, 32'h0,         2'b00, 4'hC, 2'b00, 32'h4};
      vecs[8]  = '{1'b1, 1'b0, 4'h7, 32'h0,         2'b10, 4'h4, 2'b10, 32'h2};
      vecs[9]  = '{1'b0, 1'b1, 4'hB, 32'hDEAD_BEEF, 2'b10, 4'h8, 2'b10, 32'h0};
      vecs[10] = '{1'b0, 1'b0, 4'hA, 32'h0,         2'b00, 4'h8, 2'b00, 32'hDEAD_BEEF};
      vecs[11] = '{1'b0, 1'b1, 4'h1, 32'h0000_0005, 2'b00, 4'h0, 2'b00, 32'h0};

      ARESETN = 1'b0;
      req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
      repeat (3) @(negedge ACLK);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checkOutput("rst_ctrl", 64'({req0_ready, req1_ready, req0_done, req1_done, busy,
                  M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'h0);
      checkOutput("rst_resp", 64'({req0_resp, req1_resp}), 64'h0);
      checkOutput("rst_rdata", {req0_rdata, req1_rdata}, 64'h0);
      checkOutput("const_prot_strb", 64'({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB}), 64'h00F);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge ACLK);
      ARESETN = 1'b1;

      for (int i = 0; i < 12; i++) begin
         slvBresp = vecs[i].slvResp;
         slvRresp = vecs[i].slvResp;
         b0 = done0Cnt; b1 = done1Cnt;
         applyStimulus(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata, ok, lat, resp, rdata);
         checkOutput($sformatf("v%0d_done_seen", i), 64'(ok), 64'h1);
         checkOutput($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
         if (vecs[i].we) begin
            checkOutput($sformatf("v%0d_awaddr", i), 64'(lastAwaddr), 64'(vecs[i].expAddr));
            checkOutput($sformatf("v%0d_wdata_wstrb", i), 64'({lastWdata, lastWstrb}),
                        64'({vecs[i].wdata, 4'hF}));
         end else begin
            checkOutput($sformatf("v%0d_araddr", i), 64'(lastAraddr), 64'(vecs[i].expAddr));
         end
         checkOutput($sformatf("v%0d_resp", i), 64'(resp), 64'(vecs[i].expResp));
         checkOutput($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].expRdata));
         @(negedge ACLK);
         checkOutput($sformatf("v%0d_done_counts", i), 64'({done0Cnt - b0, done1Cnt - b1}),
                     vecs[i].id ? {32'd0, 32'd1} : {32'd1, 32'd0});
         checkOutput($sformatf("v%0d_done_single", i), 64'({req0_done, req1_done, busy}), 64'h0);
      end
      slvBresp = 2'b00; slvRresp = 2'b00;

      // Both requesters keep valid asserted from reset: accepts must alternate 0,1,0,1...
      @(negedge ACLK); ARESETN = 1'b0;
      @(negedge ACLK); ARESETN = 1'b1;
      grantQ.delete();
      b0 = done0Cnt; b1 = done1Cnt; a0 = acc0; a1 = acc1;
      req0_we = 1'b0; req0_addr = 4'h0; req1_we = 1'b0; req1_addr = 4'h4;
      req0_valid = 1'b1; req1_valid = 1'b1;
      n = 0;
      while (((done0Cnt - b0) < 4 || (done1Cnt - b1) < 4) && n < 300) begin
         @(negedge ACLK); n++;
         if (acc0 - a0 >= 4) req0_valid = 1'b0;
         if (acc1 - a1 >= 4) req1_valid = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(negedge ACLK);
      checkOutput("rr_finished", 64'(n < 300), 64'h1);
      checkOutput("rr_accepts", 64'({acc0 - a0, acc1 - a1}), {32'd4, 32'd4});
      checkOutput("rr_dones", 64'({done0Cnt - b0, done1Cnt - b1}), {32'd4, 32'd4});
      ord = '0;
      for (int i = 0; i < 8 && i < grantQ.size(); i++) ord[i] = grantQ[i];
      checkOutput("rr_grant_count", 64'(grantQ.size()), 64'd8);
      checkOutput("rr_grant_order", 64'(ord), 64'hAA);

      // Slow slave: WREADY three cycles late, BVALID five cycles after the write lands.
      awDelay = 0; wDelay = 3; bDelay = 5;
      s0 = awHigh; s1 = wHigh; s2 = bReadyHigh; s3 = bWait;
      b0 = done0Cnt; b1 = done1Cnt;
      applyStimulus(1'b0, 1'b1, 4'h4, 32'h0000_0055, ok, lat, resp, rdata);
      @(negedge ACLK);
      checkOutput("slow_done_seen", 64'(ok), 64'h1);
      checkOutput("slow_latency", 64'(lat), 64'd11);
      checkOutput("slow_awvalid_cycles", 64'(awHigh - s0), 64'd1);
      checkOutput("slow_wvalid_cycles", 64'(wHigh - s1), 64'd4);
      checkOutput("slow_bready_cycles", 64'(bReadyHigh - s2), 64'd6);
      checkOutput("slow_bready_wait", 64'(bWait - s3), 64'd5);
      checkOutput("slow_done_counts", 64'({done0Cnt - b0, done1Cnt - b1}), {32'd1, 32'd0});
      wDelay = 0;

      // Reset while waiting for B: everything drops at once and the write never completes.
      bDelay = 20;
      @(negedge ACLK);
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 4'h8; req0_wdata = 32'h77;
      #1;
      n = 0;
      while (!req0_ready && n < 50) begin @(negedge ACLK); #1; n++; end
      @(posedge ACLK); #1; req0_valid = 1'b0;
      n = 0;
      while (!M_AXI_BREADY && n < 50) begin @(negedge ACLK); n++; end
      checkOutput("wb_reached", 64'(M_AXI_BREADY), 64'h1);
      b0 = done0Cnt; b1 = done1Cnt;
      ARESETN = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 4'h0;
      #1;
      checkOutput("rstwb_immediate", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                  M_AXI_RREADY, req0_ready, req1_ready, busy, req0_done, req1_done}), 64'h0);
      repeat (2) @(negedge ACLK);
      checkOutput("rstwb_held", 64'({req0_ready, req1_ready, busy, M_AXI_BREADY}), 64'h0);
      checkOutput("rstwb_no_done", 64'({done0Cnt - b0, done1Cnt - b1}), 64'h0);
      bDelay = 0;
      grantQ.delete();
      a0 = acc0; a1 = acc1;
      ARESETN = 1'b1;
      n = 0;
      while (((done0Cnt - b0) < 1 || (done1Cnt - b1) < 1) && n < 100) begin
         @(negedge ACLK); n++;
         if (acc0 > a0) req0_valid = 1'b0;
         if (acc1 > a1) req1_valid = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(negedge ACLK);
      checkOutput("post_rst_finished", 64'(n < 100), 64'h1);
      checkOutput("post_rst_first_grant", 64'(grantQ.size() > 0 ? grantQ[0] : 1'b1), 64'h0);
      checkOutput("post_rst_dones", 64'({done0Cnt - b0, done1Cnt - b1}), {32'd1, 32'd1});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
